aes_clk_gate_ctrl: RTL and testbench

AES_CLK_GATE_CTRL -- requirements
Module: aes_clk_gate_ctrl

---
 rtl/aes_clk_gate_ctrl.sv | 120 ++++++++++++
 tb/tb_aes_clk_gate_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/aes_clk_gate_ctrl.sv
// Per-domain clock gate sequencer for the AES datapath: wakes a gated clock on
// request, reports it stable after a fixed settle time, and gates it after idling.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_OFF  | clock gated; waits for req or force_on
// ST_WAKE | gate enabled, clock settling; runs WAKE_CYCLES cycles, never aborts
// ST_ON   | clock running and acknowledged
// ST_HOLD | idle hold-off; counts idle_thr+1 cycles before gating, activity returns to ON
module aes_clk_gate_ctrl #(
   parameter int N_DOM       = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_DOM-1:0] req,
   input  logic [N_DOM-1:0] busy,
   input  logic             force_on,
   input  logic [CNT_W-1:0] idle_thr,
   output logic [N_DOM-1:0] gate_en,
   output logic [N_DOM-1:0] ack,
   output logic             all_gated
);

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_WAKE = 2'd1;
   localparam logic [1:0] ST_ON   = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);

   logic [1:0]       state_q    [N_DOM];
   logic [1:0]       state_d    [N_DOM];
   logic [3:0]       wake_cnt_q [N_DOM];
   logic [3:0]       wake_cnt_d [N_DOM];
   logic [CNT_W-1:0] idle_cnt_q [N_DOM];
   logic [CNT_W-1:0] idle_cnt_d [N_DOM];
   logic [N_DOM-1:0] gate_en_q, gate_en_d;
   logic [N_DOM-1:0] ack_q, ack_d;
   logic             all_gated_q, all_gated_d;

   always_comb begin
      all_gated_d = 1'b1;
      gate_en_d   = '0;
      ack_d       = '0;
      for (int i = 0; i < N_DOM; i++) begin
         state_d[i]    = state_q[i];
         wake_cnt_d[i] = wake_cnt_q[i];
         idle_cnt_d[i] = idle_cnt_q[i];

         case (state_q[i])
            ST_OFF: begin
               if (req[i] || force_on) begin
                  state_d[i]    = ST_WAKE;
                  wake_cnt_d[i] = WAKE_LOAD;
               end
            end
            ST_WAKE: begin
               if (wake_cnt_q[i] == 4'd0) begin
                  state_d[i] = ST_ON;
               end else begin
                  wake_cnt_d[i] = wake_cnt_q[i] - 4'd1;
               end
            end
            ST_ON: begin
               if (!req[i] && !busy[i] && !force_on) begin
                  state_d[i]    = ST_HOLD;
                  idle_cnt_d[i] = idle_thr;
               end
            end
            ST_HOLD: begin
               // activity beats an expiring hold-off count
               if (req[i] || busy[i] || force_on) begin
                  state_d[i] = ST_ON;
               end else if (idle_cnt_q[i] == '0) begin
                  state_d[i] = ST_OFF;
               end else begin
                  idle_cnt_d[i] = idle_cnt_q[i] - CNT_W'(1);
               end
            end
            default: state_d[i] = ST_OFF;
         endcase

         // outputs are a registered decode of the current state, so they lag it by one edge
         gate_en_d[i] = (state_q[i] != ST_OFF);
         ack_d[i]     = (state_q[i] == ST_ON) || (state_q[i] == ST_HOLD);
         if (state_q[i] != ST_OFF) begin
            all_gated_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DOM; i++) begin
            state_q[i]    <= ST_OFF;
            wake_cnt_q[i] <= 4'd0;
            idle_cnt_q[i] <= '0;
         end
         gate_en_q   <= '0;
         ack_q       <= '0;
         all_gated_q <= 1'b1;
      end else begin
         for (int i = 0; i < N_DOM; i++) begin
            state_q[i]    <= state_d[i];
            wake_cnt_q[i] <= wake_cnt_d[i];
            idle_cnt_q[i] <= idle_cnt_d[i];
         end
         gate_en_q   <= gate_en_d;
         ack_q       <= ack_d;
         all_gated_q <= all_gated_d;
      end
   end

   assign gate_en   = gate_en_q;
   assign ack       = ack_q;
   assign all_gated = all_gated_q;

endmodule

// File: tb/tb_aes_clk_gate_ctrl.sv
// Scoreboard bench for aes_clk_gate_ctrl: directed phases push expected outputs
// tagged with an edge number; a negedge monitor pops and compares them.
module tb_aes_clk_gate_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] busy;
   logic       force_on;
   logic [7:0] idle_thr;
   logic [3:0] gate_en;
   logic [3:0] ack;
   logic       all_gated;

   aes_clk_gate_ctrl #(.N_DOM(4), .WAKE_CYCLES(2), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .busy      (busy),
      .force_on  (force_on),
      .idle_thr  (idle_thr),
      .gate_en   (gate_en),
      .ack       (ack),
      .all_gated (all_gated)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int         cyc;
      logic [3:0] ge;
      logic [3:0] ak;
      logic       ag;
      string      nm;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   errors = 0;
   int   checks = 0;

   task automatic expect_at(input int cyc, input logic [3:0] ge, input logic [3:0] ak,
                            input logic ag, input string nm);
      exp_t e;
      e.cyc = cyc; e.ge = ge; e.ak = ak; e.ag = ag; e.nm = nm;
      sb_q.push_back(e);
   endtask

   task automatic wait_to(input int e);
      while (edge_cnt < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: outputs are sampled mid-cycle, after edge number edge_cnt
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
         cur = sb_q.pop_front();
         checks++;
         if (cur.cyc < edge_cnt) begin
            errors++;
            $display("FAIL %s: stale entry for edge %0d seen at edge %0d", cur.nm, cur.cyc, edge_cnt);
         end else if (gate_en !== cur.ge || ack !== cur.ak || all_gated !== cur.ag) begin
            errors++;
            $display("FAIL %s @edge %0d: got gate_en=%b ack=%b all_gated=%b, want gate_en=%b ack=%b all_gated=%b",
                     cur.nm, edge_cnt, gate_en, ack, all_gated, cur.ge, cur.ak, cur.ag);
         end
      end
   end

   int b;

   initial begin
      rst_n    = 1'b0;
      req      = 4'b0000;
      busy     = 4'b0000;
      force_on = 1'b0;
      idle_thr = 8'd3;

      // reset held with clock running
      expect_at(2, 4'b0000, 4'b0000, 1'b1, "reset_state");
      expect_at(3, 4'b0000, 4'b0000, 1'b1, "reset_state_hold");
      wait_to(3);

      // wake domain 0 straight out of reset, then idle it down
      b = edge_cnt;
      expect_at(b+1,  4'b0000, 4'b0000, 1'b1, "wake_lag");
      expect_at(b+2,  4'b0001, 4'b0000, 1'b0, "gate_en_rise");
      expect_at(b+3,  4'b0001, 4'b0000, 1'b0, "wake_no_ack");
      expect_at(b+4,  4'b0001, 4'b0001, 1'b0, "ack_rise");
      expect_at(b+9,  4'b0001, 4'b0001, 1'b0, "hold_last");
      expect_at(b+10, 4'b0000, 4'b0000, 1'b1, "hold_to_off");
      rst_n = 1'b1;
      req   = 4'b0001;
      wait_to(b+4);
      req = 4'b0000;
      wait_to(b+10);

      // busy at zero idle count keeps domain 0 on
      b = edge_cnt;
      expect_at(b+4,  4'b0001, 4'b0001, 1'b0, "rewake_ack");
      expect_at(b+10, 4'b0001, 4'b0001, 1'b0, "busy_wins_zero");
      expect_at(b+11, 4'b0001, 4'b0001, 1'b0, "busy_stay_on");
      expect_at(b+16, 4'b0001, 4'b0001, 1'b0, "busy_hold_last");
      expect_at(b+17, 4'b0000, 4'b0000, 1'b1, "busy_then_off");
      req = 4'b0001;
      wait_to(b+4);
      req = 4'b0000;
      wait_to(b+8);
      busy = 4'b0001;
      wait_to(b+11);
      busy = 4'b0000;
      wait_to(b+17);

      // force_on wakes every domain and pins them on
      b = edge_cnt;
      expect_at(b+2,  4'b1111, 4'b0000, 1'b0, "force_gate_en");
      expect_at(b+4,  4'b1111, 4'b1111, 1'b0, "force_ack_all");
      expect_at(b+9,  4'b1111, 4'b1111, 1'b0, "force_pins_on");
      expect_at(b+14, 4'b1111, 4'b1111, 1'b0, "force_hold_last");
      expect_at(b+15, 4'b0000, 4'b0000, 1'b1, "force_release_off");
      force_on = 1'b1;
      wait_to(b+3);
      req = 4'b1111;
      wait_to(b+5);
      req = 4'b0000;
      wait_to(b+9);
      force_on = 1'b0;
      wait_to(b+15);

      // async reset mid-WAKE on domains 1 and 2
      b = edge_cnt;
      expect_at(b+2, 4'b0000, 4'b0000, 1'b1, "async_reset");
      expect_at(b+3, 4'b0000, 4'b0000, 1'b1, "reset_held");
      expect_at(b+6, 4'b0000, 4'b0000, 1'b1, "post_reset_gated");
      expect_at(b+8, 4'b0000, 4'b0000, 1'b1, "post_reset_still");
      req = 4'b0110;
      wait_to(b+2);
      rst_n = 1'b0;
      req   = 4'b0000;
      wait_to(b+4);
      rst_n = 1'b1;
      wait_to(b+8);

      // one-cycle req pulse on domain 3
      b = edge_cnt;
      expect_at(b+2, 4'b1000, 4'b0000, 1'b0, "pulse_gate_en");
      expect_at(b+4, 4'b1000, 4'b1000, 1'b0, "pulse_ack");
      expect_at(b+8, 4'b1000, 4'b1000, 1'b0, "pulse_hold_last");
      expect_at(b+9, 4'b0000, 4'b0000, 1'b1, "pulse_off");
      req = 4'b1000;
      wait_to(b+1);
      req = 4'b0000;
      wait_to(b+9);

      // idle_thr=0 gives a single HOLD cycle
      b = edge_cnt;
      expect_at(b+4, 4'b0100, 4'b0100, 1'b0, "thr0_on");
      expect_at(b+5, 4'b0100, 4'b0100, 1'b0, "thr0_hold");
      expect_at(b+6, 4'b0000, 4'b0000, 1'b1, "thr0_off");
      idle_thr = 8'd0;
      req      = 4'b0100;
      wait_to(b+3);
      req = 4'b0000;
      wait_to(b+6);

      // idle_thr changed during HOLD is ignored
      b = edge_cnt;
      expect_at(b+8, 4'b0001, 4'b0001, 1'b0, "thr_no_resample_hold");
      expect_at(b+9, 4'b0000, 4'b0000, 1'b1, "thr_no_resample_off");
      idle_thr = 8'd3;
      req      = 4'b0001;
      wait_to(b+3);
      req = 4'b0000;
      wait_to(b+4);
      idle_thr = 8'd200;
      wait_to(b+11);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
